// File: rtl/uart_tx_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_tx_sched
// Purpose  : FIFO-buffered frame sequencer for one uart_core_tx instance, with
//            shadowed line configuration applied only between frames.
// Option   : UART_TX_SCHED_GAP_EN inserts GAP_CYCLES idle cycles after frames.
// Revision : 1.0  initial release
// ============================================================================
module uart_tx_sched #(
    parameter int DEPTH          = 16,
    parameter int ADDR_WIDTH     = 4,
    parameter int BAUD_DIV_WIDTH = 8,
    parameter int GAP_CYCLES     = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [7:0]                wr_data,
    output logic                      full,
    output logic                      empty,
    output logic [ADDR_WIDTH:0]       count,
    output logic                      ovf,
    input  logic                      cfg_wr,
    input  logic [BAUD_DIV_WIDTH-1:0] cfg_baud_div,
    input  logic [1:0]                cfg_data_type,
    input  logic [1:0]                cfg_stop_type,
    input  logic                      cfg_check_en,
    input  logic [1:0]                cfg_check_type,
    output logic [BAUD_DIV_WIDTH-1:0] baud_div,
    output logic [1:0]                data_type,
    output logic [1:0]                stop_type,
    output logic                      check_en,
    output logic [1:0]                check_type,
    output logic                      tx_en,
    output logic [7:0]                tx_data,
    input  logic                      tx_busy,
    input  logic                      tx_ack,
    output logic                      idle,
    output logic                      sent
);

    localparam int                  c_CFG_W   = BAUD_DIV_WIDTH + 7;
    localparam logic [ADDR_WIDTH:0] c_DEPTH   = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] c_CNT_ONE = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] c_PTR_ONE = ADDR_WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    state_t                  r_state_q,   w_state_d;
    logic [ADDR_WIDTH-1:0]   r_wr_ptr_q,  w_wr_ptr_d;
    logic [ADDR_WIDTH-1:0]   r_rd_ptr_q,  w_rd_ptr_d;
    logic [ADDR_WIDTH:0]     r_count_q,   w_count_d;
    logic                    r_full_q,    w_full_d;
    logic                    r_empty_q,   w_empty_d;
    logic                    r_ovf_q,     w_ovf_d;
    logic                    r_tx_en_q,   w_tx_en_d;
    logic [7:0]              r_tx_data_q, w_tx_data_d;
    logic                    r_sent_q,    w_sent_d;
    logic                    r_pend_q,    w_pend_d;
    logic [c_CFG_W-1:0]      r_shadow_q,  w_shadow_d;
    logic [c_CFG_W-1:0]      r_active_q,  w_active_d;
    logic [7:0]              r_mem_q [DEPTH];

    logic                    w_push;
    logic                    w_pop;
    logic                    w_apply;

`ifdef UART_TX_SCHED_GAP_EN
    localparam int                 c_GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [c_GAP_W-1:0] c_GAP_LOAD = c_GAP_W'(GAP_CYCLES - 1);
    localparam logic [c_GAP_W-1:0] c_GAP_ONE  = c_GAP_W'(1);
    logic [c_GAP_W-1:0]            r_gap_cnt_q, w_gap_cnt_d;
`endif

    // full is the registered value, so a write while full is dropped even if a pop coincides.
    assign w_push  = wr_en & ~r_full_q;
    assign w_pop   = (r_state_q == S_IDLE) & ~r_empty_q & ~tx_busy;
    assign w_apply = (r_state_q == S_IDLE) & r_pend_q;

    always_comb begin
        w_state_d   = r_state_q;
        w_wr_ptr_d  = w_push ? r_wr_ptr_q + c_PTR_ONE : r_wr_ptr_q;
        w_rd_ptr_d  = w_pop  ? r_rd_ptr_q + c_PTR_ONE : r_rd_ptr_q;
        w_count_d   = r_count_q;
        w_ovf_d     = wr_en & r_full_q;
        w_tx_en_d   = 1'b0;
        w_tx_data_d = r_tx_data_q;
        w_sent_d    = 1'b0;
        w_shadow_d  = cfg_wr ? {cfg_baud_div, cfg_data_type, cfg_stop_type,
                                cfg_check_en, cfg_check_type} : r_shadow_q;
        // A cfg_wr coinciding with an apply keeps the flag so the newer values follow.
        w_pend_d    = cfg_wr | (r_pend_q & ~w_apply);
        w_active_d  = w_apply ? r_shadow_q : r_active_q;
`ifdef UART_TX_SCHED_GAP_EN
        w_gap_cnt_d = r_gap_cnt_q;
`endif

        case ({w_push, w_pop})
            2'b10:   w_count_d = r_count_q + c_CNT_ONE;
            2'b01:   w_count_d = r_count_q - c_CNT_ONE;
            default: w_count_d = r_count_q;
        endcase
        w_full_d  = (w_count_d == c_DEPTH);
        w_empty_d = (w_count_d == '0);

        case (r_state_q)
            S_IDLE: begin
                if (w_pop) begin
                    w_tx_data_d = r_mem_q[r_rd_ptr_q];
                    w_tx_en_d   = 1'b1;
                    w_state_d   = S_START;
                end
            end
            S_START: w_state_d = S_WAIT;
            S_WAIT: begin
                if (tx_ack) begin
                    w_sent_d    = 1'b1;
`ifdef UART_TX_SCHED_GAP_EN
                    w_state_d   = S_GAP;
                    w_gap_cnt_d = c_GAP_LOAD;
`else
                    w_state_d   = S_IDLE;
`endif
                end
            end
            S_GAP: begin
`ifdef UART_TX_SCHED_GAP_EN
                if (r_gap_cnt_q == '0) begin
                    w_state_d = S_IDLE;
                end else begin
                    w_gap_cnt_d = r_gap_cnt_q - c_GAP_ONE;
                end
`else
                w_state_d = S_IDLE;
`endif
            end
            default: w_state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q   <= S_IDLE;
            r_wr_ptr_q  <= '0;
            r_rd_ptr_q  <= '0;
            r_count_q   <= '0;
            r_full_q    <= 1'b0;
            r_empty_q   <= 1'b1;
            r_ovf_q     <= 1'b0;
            r_tx_en_q   <= 1'b0;
            r_tx_data_q <= '0;
            r_sent_q    <= 1'b0;
            r_pend_q    <= 1'b0;
            r_shadow_q  <= '0;
            r_active_q  <= '0;
`ifdef UART_TX_SCHED_GAP_EN
            r_gap_cnt_q <= '0;
`endif
        end else begin
            r_state_q   <= w_state_d;
            r_wr_ptr_q  <= w_wr_ptr_d;
            r_rd_ptr_q  <= w_rd_ptr_d;
            r_count_q   <= w_count_d;
            r_full_q    <= w_full_d;
            r_empty_q   <= w_empty_d;
            r_ovf_q     <= w_ovf_d;
            r_tx_en_q   <= w_tx_en_d;
            r_tx_data_q <= w_tx_data_d;
            r_sent_q    <= w_sent_d;
            r_pend_q    <= w_pend_d;
            r_shadow_q  <= w_shadow_d;
            r_active_q  <= w_active_d;
`ifdef UART_TX_SCHED_GAP_EN
            r_gap_cnt_q <= w_gap_cnt_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_q[r_wr_ptr_q] <= wr_data;
        end
    end

    assign full    = r_full_q;
    assign empty   = r_empty_q;
    assign count   = r_count_q;
    assign ovf     = r_ovf_q;
    assign tx_en   = r_tx_en_q;
    assign tx_data = r_tx_data_q;
    assign sent    = r_sent_q;
    assign idle    = r_empty_q & (r_state_q == S_IDLE) & ~tx_busy;
    assign {baud_div, data_type, stop_type, check_en, check_type} = r_active_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_sched
// Purpose  : Scoreboard bench for uart_tx_sched with a behavioural core model.
// Revision : 1.0  initial release
// ============================================================================
module tb_uart_tx_sched;

    localparam int AW  = 4;
    localparam int BDW = 8;
`ifdef UART_TX_SCHED_GAP_EN
    localparam int EXP_SPACING = 18;
`else
    localparam int EXP_SPACING = 2;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic           wr_en;
    logic [7:0]     wr_data;
    logic           full, empty, ovf;
    logic [AW:0]    count;
    logic           cfg_wr;
    logic [BDW-1:0] cfg_baud_div;
    logic [1:0]     cfg_data_type, cfg_stop_type, cfg_check_type;
    logic           cfg_check_en;
    logic [BDW-1:0] baud_div;
    logic [1:0]     data_type, stop_type, check_type;
    logic           check_en;
    logic           tx_en;
    logic [7:0]     tx_data;
    logic           tx_busy, tx_ack;
    logic           idle, sent;

    logic           busy_m    = 1'b0;
    logic           hold_busy = 1'b0;
    assign tx_busy = busy_m | hold_busy;

    int         errors = 0;
    int         checks = 0;
    logic [7:0] sb [$];
    logic [7:0] exp_b;
    int         cyc = 0, ack_cyc = -1, n_sent = 0, n_tx = 0;
    int         ack_delay = 4, core_cnt = 0;
    bit         chk_spacing = 1'b0;

    uart_tx_sched #(.DEPTH(16), .ADDR_WIDTH(AW), .BAUD_DIV_WIDTH(BDW), .GAP_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
        .full(full), .empty(empty), .count(count), .ovf(ovf),
        .cfg_wr(cfg_wr), .cfg_baud_div(cfg_baud_div), .cfg_data_type(cfg_data_type),
        .cfg_stop_type(cfg_stop_type), .cfg_check_en(cfg_check_en), .cfg_check_type(cfg_check_type),
        .baud_div(baud_div), .data_type(data_type), .stop_type(stop_type),
        .check_en(check_en), .check_type(check_type),
        .tx_en(tx_en), .tx_data(tx_data), .tx_busy(tx_busy), .tx_ack(tx_ack),
        .idle(idle), .sent(sent)
    );

    always #5 clk = ~clk;

    // Monitor and core model share one process so ack timestamps and frame checks never race.
    always @(negedge clk) begin
        cyc++;
        if (sent) n_sent++;
        if (tx_en) begin
            n_tx++;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_data: tx_en with tx_data=%02h but nothing expected", tx_data);
            end else begin
                exp_b = sb.pop_front();
                if (tx_data !== exp_b) begin
                    errors++;
                    $display("FAIL sb_data: tx_data=%02h expected %02h", tx_data, exp_b);
                end
            end
            if (chk_spacing && ack_cyc >= 0) begin
                checks++;
                if (cyc - ack_cyc != EXP_SPACING) begin
                    errors++;
                    $display("FAIL ack_to_tx_en: spacing=%0d expected %0d", cyc - ack_cyc, EXP_SPACING);
                end
            end
        end
        if (rst) begin
            busy_m = 1'b0; tx_ack = 1'b0; core_cnt = 0;
        end else if (core_cnt > 0) begin
            core_cnt--;
            if (core_cnt == 0) begin
                tx_ack  = 1'b1;
                ack_cyc = cyc;
            end
        end else if (tx_ack) begin
            tx_ack = 1'b0;
            busy_m = 1'b0;
        end
        if (!rst && tx_en && !busy_m) begin
            busy_m   = 1'b1;
            core_cnt = ack_delay;
        end
    end

    task automatic wait_sent(input int target, input int limit, output bit ok);
        for (int i = 0; i < limit && n_sent < target; i++) @(negedge clk);
        ok = (n_sent >= target);
    endtask

    task automatic wait_tx_en(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit && !ok; i++) begin
            @(negedge clk);
            ok = tx_en;
        end
    endtask

    task automatic write_byte(input logic [7:0] b, input bit expect_out);
        @(negedge clk);
        wr_en = 1'b1; wr_data = b;
        if (expect_out) sb.push_back(b);
    endtask

    task automatic test_reset();
        logic [18:0] st;
        rst = 1'b1; wr_en = 1'b0; wr_data = '0; cfg_wr = 1'b0; cfg_baud_div = '0;
        cfg_data_type = '0; cfg_stop_type = '0; cfg_check_en = 1'b0; cfg_check_type = '0;
        tx_ack = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        st = {full, empty, count, ovf, tx_en, tx_data, idle, sent};
        checks++;
        if (st !== {1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset_outputs: got %05h expected %05h", st,
                     {1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0});
        end
        checks++;
        if ({baud_div, data_type, stop_type, check_en, check_type} !== 15'h0) begin
            errors++;
            $display("FAIL reset_cfg: got %04h expected 0000",
                     {baud_div, data_type, stop_type, check_en, check_type});
        end
    endtask

    task automatic test_single();
        int s0; bit ok;
        s0 = n_sent; ack_delay = 5;
        write_byte(8'hA5, 1'b1);
        @(negedge clk); wr_en = 1'b0;
        checks++;
        if (tx_en !== 1'b0) begin
            errors++; $display("FAIL latency_early: tx_en=%b expected 0", tx_en);
        end
        @(negedge clk);
        checks++;
        if (tx_en !== 1'b1 || tx_data !== 8'hA5) begin
            errors++; $display("FAIL latency_2: tx_en=%b tx_data=%02h expected 1/a5", tx_en, tx_data);
        end
        wait_sent(s0 + 1, 40, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL single_sent: sent count=%0d expected %0d", n_sent - s0, 1); end
        repeat (3) @(negedge clk);
        checks++;
        if (n_sent - s0 !== 1) begin errors++; $display("FAIL sent_once: sent pulses=%0d expected 1", n_sent - s0); end
        checks++;
        if (idle !== 1'b1) begin errors++; $display("FAIL single_idle: idle=%b expected 1", idle); end
    endtask

    task automatic test_fill_order();
        int s0, t0; bit ok;
        s0 = n_sent; t0 = n_tx; ack_delay = 3; hold_busy = 1'b1;
        for (int i = 1; i <= 16; i++) write_byte(8'(i), 1'b1);
        @(negedge clk);
        checks++;
        if (full !== 1'b1 || count !== 5'd16) begin
            errors++; $display("FAIL fill_full: full=%b count=%0d expected 1/16", full, count);
        end
        wr_en = 1'b1; wr_data = 8'hEE;
        @(negedge clk); wr_en = 1'b0;
        checks++;
        if (ovf !== 1'b1 || count !== 5'd16) begin
            errors++; $display("FAIL fill_ovf: ovf=%b count=%0d expected 1/16", ovf, count);
        end
        @(negedge clk);
        checks++;
        if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_pulse: ovf=%b expected 0", ovf); end
        ack_cyc = -1; chk_spacing = 1'b1; hold_busy = 1'b0;
        wait_sent(s0 + 16, 800, ok);
        chk_spacing = 1'b0;
        checks++;
        if (!ok || n_tx - t0 !== 16) begin
            errors++; $display("FAIL fill_frames: frames=%0d expected 16", n_tx - t0);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_cfg_mid();
        int s0; bit ok, bad, seen;
        s0 = n_sent; ack_delay = 8;
        write_byte(8'h3C, 1'b1);
        @(negedge clk); wr_en = 1'b0;
        wait_tx_en(10, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL cfg_mid_start: tx_en=%b expected 1", tx_en); end
        repeat (2) @(negedge clk);
        cfg_wr = 1'b1; cfg_data_type = 2'b11;
        wr_en = 1'b1; wr_data = 8'hC3; sb.push_back(8'hC3);
        @(negedge clk); cfg_wr = 1'b0; wr_en = 1'b0;
        bad = 1'b0; seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (data_type !== 2'b00) bad = 1'b1;
            if (sent) seen = 1'b1;
        end
        checks++;
        if (bad || !seen) begin
            errors++; $display("FAIL cfg_hold: data_type=%b changed mid-frame or no ack, expected 00", data_type);
        end
        wait_tx_en(10, ok);
        checks++;
        if (!ok || data_type !== 2'b11) begin
            errors++; $display("FAIL cfg_next_frame: data_type=%b expected 11", data_type);
        end
        wait_sent(s0 + 2, 60, ok);
        repeat (3) @(negedge clk);
    endtask

    task automatic test_cfg_idle();
        @(negedge clk);
        cfg_wr = 1'b1; cfg_baud_div = 8'h37; cfg_data_type = 2'b01; cfg_stop_type = 2'b10;
        cfg_check_en = 1'b1; cfg_check_type = 2'b11;
        @(negedge clk);
        cfg_baud_div = 8'h5A; cfg_data_type = 2'b10; cfg_stop_type = 2'b01;
        cfg_check_en = 1'b0; cfg_check_type = 2'b01;
        @(negedge clk); cfg_wr = 1'b0;
        checks++;
        if ({baud_div, data_type, stop_type, check_en, check_type} !== {8'h37, 2'b01, 2'b10, 1'b1, 2'b11}) begin
            errors++; $display("FAIL cfg_idle_apply: got %04h expected %04h",
                {baud_div, data_type, stop_type, check_en, check_type}, {8'h37, 2'b01, 2'b10, 1'b1, 2'b11});
        end
        @(negedge clk);
        checks++;
        if ({baud_div, data_type, stop_type, check_en, check_type} !== {8'h5A, 2'b10, 2'b01, 1'b0, 2'b01}) begin
            errors++; $display("FAIL cfg_same_cycle: got %04h expected %04h",
                {baud_div, data_type, stop_type, check_en, check_type}, {8'h5A, 2'b10, 2'b01, 1'b0, 2'b01});
        end
    endtask

    task automatic test_push_pop();
        int s0; bit ok;
        s0 = n_sent; ack_delay = 3; hold_busy = 1'b1;
        for (int i = 0; i < 5; i++) write_byte(8'h50 + 8'(i), 1'b1);
        @(negedge clk);
        checks++;
        if (count !== 5'd5) begin errors++; $display("FAIL pp_count5: count=%0d expected 5", count); end
        hold_busy = 1'b0; wr_en = 1'b1; wr_data = 8'h55; sb.push_back(8'h55);
        @(negedge clk);
        hold_busy = 1'b1; wr_en = 1'b0;
        checks++;
        if (count !== 5'd5) begin errors++; $display("FAIL pp_same_cycle: count=%0d expected 5", count); end
        wait_sent(s0 + 1, 30, ok);
        @(negedge clk);
        for (int i = 0; i < 11; i++) write_byte(8'h60 + 8'(i), 1'b1);
        @(negedge clk);
        checks++;
        if (full !== 1'b1) begin errors++; $display("FAIL pp_full: full=%b expected 1", full); end
        hold_busy = 1'b0; wr_en = 1'b1; wr_data = 8'hEE;
        @(negedge clk); wr_en = 1'b0;
        checks++;
        if (ovf !== 1'b1 || count !== 5'd15) begin
            errors++; $display("FAIL pp_full_pop_drop: ovf=%b count=%0d expected 1/15", ovf, count);
        end
        wait_sent(s0 + 17, 600, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL pp_drain: frames=%0d expected 17", n_sent - s0); end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_midframe();
        int s0; bit ok;
        ack_delay = 30; s0 = n_sent;
        for (int i = 0; i < 4; i++) write_byte(8'h70 + 8'(i), 1'b1);
        @(negedge clk); wr_en = 1'b0;
        wait_tx_en(10, ok);
        repeat (2) @(negedge clk);
        checks++;
        if (count !== 5'd3) begin errors++; $display("FAIL rst_pre_count: count=%0d expected 3", count); end
        rst = 1'b1;
        @(negedge clk); #1;
        checks++;
        if (count !== 5'd0 || tx_en !== 1'b0 || idle !== 1'b1 || empty !== 1'b1 || full !== 1'b0) begin
            errors++; $display("FAIL rst_midframe: count=%0d tx_en=%b idle=%b empty=%b expected 0/0/1/1",
                               count, tx_en, idle, empty);
        end
        checks++;
        if ({baud_div, data_type, stop_type, check_en, check_type} !== 15'h0) begin
            errors++; $display("FAIL rst_cfg: got %04h expected 0000",
                               {baud_div, data_type, stop_type, check_en, check_type});
        end
        rst = 1'b0; sb.delete(); ack_delay = 4;
        s0 = n_sent;
        write_byte(8'h99, 1'b1);
        @(negedge clk); wr_en = 1'b0;
        wait_sent(s0 + 1, 40, ok);
        checks++;
        if (!ok || n_sent - s0 !== 1) begin
            errors++; $display("FAIL rst_recover: frames=%0d expected 1", n_sent - s0);
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_order();
        test_cfg_mid();
        test_cfg_idle();
        test_push_pop();
        test_reset_midframe();
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL sb_empty: %0d frames outstanding expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
